mem_arbiter: RTL

Two-master arbiter sharing the single 12-bit-address, 16-bit-data memory port between the CPU (master 0) and a DMA/program loader (master 1). It accepts en/rdwr requests from each master, grants one at a time with round-robin priority, and drives the memory-side en/rdwr handshake. It returns read data and a one-cycle ack to the granted master. It sits between the masters and the memory model; tri-state conversion to the shared inout data bus is done at top level.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master round-robin arbiter for a single 12-bit address /
//                16-bit data memory port. Master 0 is the CPU, master 1 is
//                the DMA/program loader. All outputs are registered.
//                Optional macro ARB_TIMEOUT_EN adds an ACCESS-state timeout
//                that aborts a stalled access after TIMEOUT cycles.
//  Reset       : rst_n, asynchronous, active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT = 15                 // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_en,
   input  logic        m0_rdwr,
   input  logic [11:0] m0_addr,
   input  logic [15:0] m0_wdata,
   output logic [15:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_en,
   input  logic        m1_rdwr,
   input  logic [11:0] m1_addr,
   input  logic [15:0] m1_wdata,
   output logic [15:0] m1_rdata,
   output logic        m1_ack,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rdwr,
   output logic        mem_en,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        owner,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        last, last_nxt;
   logic        owner_nxt;
   logic [11:0] addr_nxt;
   logic [15:0] wdata_nxt;
   logic        rdwr_nxt;
   logic        en_nxt;
   logic [15:0] rdata0_nxt, rdata1_nxt;
   logic        ack0_nxt, ack1_nxt;
   logic        err_nxt;
   logic        busy_nxt;
   logic        win;
   logic        abort;
   logic [15:0] rd_val;

`ifdef ARB_TIMEOUT_EN
   // Compared against count+1 so the abort lands exactly TIMEOUT edges after grant
   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
   logic [7:0] cnt, cnt_nxt;

   // Timeout counter: cleared on grant, advanced every ACCESS cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= 8'd0;
      else        cnt <= cnt_nxt;
   end
`else
   // Timeout depth is irrelevant when the feature is compiled out
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;          // master 0 wins the first tie
         owner     <= 1'b0;
         mem_addr  <= 12'd0;
         mem_wdata <= 16'd0;
         mem_rdwr  <= 1'b0;
         mem_en    <= 1'b0;
         m0_rdata  <= 16'd0;
         m1_rdata  <= 16'd0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         owner     <= owner_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         mem_rdwr  <= rdwr_nxt;
         mem_en    <= en_nxt;
         m0_rdata  <= rdata0_nxt;
         m1_rdata  <= rdata1_nxt;
         m0_ack    <= ack0_nxt;
         m1_ack    <= ack1_nxt;
         err       <= err_nxt;
         busy      <= busy_nxt;
      end
   end

   // Arbitration, access tracking and next-output computation
   always_comb begin
      state_nxt  = state;
      last_nxt   = last;
      owner_nxt  = owner;
      addr_nxt   = mem_addr;
      wdata_nxt  = mem_wdata;
      rdwr_nxt   = mem_rdwr;
      en_nxt     = mem_en;
      rdata0_nxt = m0_rdata;
      rdata1_nxt = m1_rdata;
      ack0_nxt   = 1'b0;
      ack1_nxt   = 1'b0;
      err_nxt    = 1'b0;
      win        = 1'b0;
      abort      = 1'b0;
      rd_val     = mem_rdata;
`ifdef ARB_TIMEOUT_EN
      cnt_nxt    = cnt;
`endif

      case (state)
         IDLE: begin
            if (m0_en || m1_en) begin
               // Tie goes to the master that did not win last time
               win       = (m0_en && m1_en) ? ~last : m1_en;
               addr_nxt  = win ? m1_addr  : m0_addr;
               wdata_nxt = win ? m1_wdata : m0_wdata;
               rdwr_nxt  = win ? m1_rdwr  : m0_rdwr;
               owner_nxt = win;
               last_nxt  = win;
               en_nxt    = 1'b1;
               state_nxt = ACCESS;
`ifdef ARB_TIMEOUT_EN
               cnt_nxt   = 8'd0;
`endif
            end
         end

         ACCESS: begin
`ifdef ARB_TIMEOUT_EN
            cnt_nxt = cnt + 8'd1;
            // A real mem_ack in the same cycle takes precedence over the abort
            abort   = !mem_ack && (({1'b0, cnt} + 9'd1) == TIMEOUT_LIM);
`endif
            if (mem_ack || abort) begin
               en_nxt    = 1'b0;
               err_nxt   = abort;
               state_nxt = RESP;
               rd_val    = abort ? 16'hFFFF : mem_rdata;
               if (!mem_rdwr) begin
                  if (owner) rdata1_nxt = rd_val;
                  else       rdata0_nxt = rd_val;
               end
               if (owner) ack1_nxt = 1'b1;
               else       ack0_nxt = 1'b1;
            end
         end

         RESP: begin
            // Requests seen here are stale (still held from the finished access)
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule
`default_nettype wire
